// File: rtl/quad_color_ctrl.sv
// Debounced press / auto-step tick -> one recolour request, committed 1 cycle after frame_end.
// Requests arriving while one is already in flight are dropped and counted (saturating).
module quad_color_ctrl #(
  parameter int COLOR_W         = 12,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int AUTO_FRAMES     = 60
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               boton,
  input  logic [COLOR_W-1:0] ran,
  input  logic               frame_end,
  input  logic               auto_en,
  output logic [1:0]         cont,
  output logic [COLOR_W-1:0] colora,
  output logic [COLOR_W-1:0] colorb,
  output logic [COLOR_W-1:0] colorc,
  output logic [COLOR_W-1:0] colord,
  output logic               pending,
  output logic               commit,
  output logic [7:0]         drop_cnt
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int FC_W = $clog2(AUTO_FRAMES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(AUTO_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, COMMIT} state_t;

  state_t             state;
  logic               sync_meta, sync, stable, stable_d, press;
  logic [DB_W-1:0]    db_cnt;
  logic [FC_W-1:0]    fcnt;
  logic               tick;
  logic               req;
  logic [COLOR_W-1:0] pcol;
  logic [1:0]         ptgt;
  logic [COLOR_W-1:0] col [4];

  assign req    = press | tick;
  assign colora = col[0];
  assign colorb = col[1];
  assign colorc = col[2];
  assign colord = col[3];

  // Button path: 2-FF synchroniser, stability counter, rising-edge pulse on the debounced level.
  always_ff @(posedge CLK) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      stable    <= 1'b0;
      stable_d  <= 1'b0;
      press     <= 1'b0;
      db_cnt    <= '0;
    end else begin
      sync_meta <= boton;
      sync      <= sync_meta;
      stable_d  <= stable;
      press     <= stable & ~stable_d;
      if (sync == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        stable <= sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      fcnt <= '0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (!auto_en) begin
        fcnt <= '0;
      end else if (frame_end) begin
        if (fcnt == FC_LAST) begin
          fcnt <= '0;
          tick <= 1'b1;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  // The colour write happens on the frame_end edge; the COMMIT state is the cycle commit is high.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state    <= IDLE;
      pcol     <= '0;
      ptgt     <= '0;
      pending  <= 1'b0;
      commit   <= 1'b0;
      cont     <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < 4; i++) col[i] <= '0;
    end else begin
      commit <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            pcol    <= ran;
            ptgt    <= cont;
            pending <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (req && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          if (frame_end) begin
            col[ptgt] <= pcol;
            cont      <= ptgt + 2'd1;
            commit    <= 1'b1;
            pending   <= 1'b0;
            state     <= COMMIT;
          end
        end
        COMMIT: begin
          if (req && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
